vec_elem_mul: RTL and testbench

//   Element-wise FP32 product of two vectors (activations x weights), one mul_fp issue per cycle.

---
 rtl/vec_elem_mul_if.sv | 17 +
 rtl/vec_elem_mul.sv | 188 ++++++++++++++++++
 tb/tb_vec_elem_mul.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vec_elem_mul_if.sv
// Handshake/data bundle between a vec_elem_mul issuer and the multiplier block.
// The nonfinite flag exists only when VEC_MUL_NONFINITE_EN is defined.
interface vec_elem_mul_if #(parameter int VECTOR_LEN = 4);
  logic                        enable;
  logic [VECTOR_LEN-1:0][31:0] vec_a;
  logic [VECTOR_LEN-1:0][31:0] vec_b;
  logic [VECTOR_LEN-1:0][31:0] result;
  logic                        done;
`ifdef VEC_MUL_NONFINITE_EN
  logic                        nonfinite;
  modport master (output enable, vec_a, vec_b, input result, done, nonfinite);
  modport slave  (input enable, vec_a, vec_b, output result, done, nonfinite);
`else
  modport master (output enable, vec_a, vec_b, input result, done);
  modport slave  (input enable, vec_a, vec_b, output result, done);
`endif
endinterface

// File: rtl/vec_elem_mul.sv
// Element-wise FP32 vector product, one mul_fp issue per cycle, tags tracked in vld/idx pipes.
// Optional feature macro: VEC_MUL_NONFINITE_EN (sticky Inf/NaN flag on writebacks).
package latency;
  localparam int MUL_FP = 3;
endpackage

// Three-stage FP32 multiplier: decode/multiply, normalise/round, pack. Subnormals read as zero.
module mul_fp (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic s1_sign, s1_nan, s1_inf, s1_zero;
  logic signed [9:0] s1_exp;
  logic [47:0] s1_prod;
  logic s2_sign, s2_nan, s2_inf, s2_zero;
  logic signed [9:0] s2_exp;
  logic [22:0] s2_frac;
  logic signed [9:0] n_exp;
  logic [23:0] mant;
  logic [24:0] rnd;
  logic guard, sticky;
  logic [22:0] frac;

  assign a_zero = (a[30:23] == 8'h00);
  assign b_zero = (b[30:23] == 8'h00);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

  // Round to nearest even on the 24-bit significand taken from the product's leading one.
  always_comb begin
    n_exp  = s1_exp;
    mant   = s1_prod[46:23];
    guard  = s1_prod[22];
    sticky = |s1_prod[21:0];
    if (s1_prod[47]) begin
      n_exp  = s1_exp + 10'sd1;
      mant   = s1_prod[47:24];
      guard  = s1_prod[23];
      sticky = |s1_prod[22:0];
    end
    rnd  = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    frac = rnd[24] ? rnd[23:1] : rnd[22:0];
    if (rnd[24]) n_exp = n_exp + 10'sd1;
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      {s1_sign, s1_nan, s1_inf, s1_zero} <= '0;
      s1_exp  <= '0;
      s1_prod <= '0;
      {s2_sign, s2_nan, s2_inf, s2_zero} <= '0;
      s2_exp  <= '0;
      s2_frac <= '0;
      q       <= '0;
    end else begin
      s1_sign <= a[31] ^ b[31];
      s1_nan  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      s1_inf  <= a_inf | b_inf;
      s1_zero <= a_zero | b_zero;
      s1_exp  <= {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
      s1_prod <= 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});

      s2_sign <= s1_sign;
      s2_nan  <= s1_nan;
      s2_inf  <= s1_inf;
      s2_zero <= s1_zero;
      s2_exp  <= n_exp;
      s2_frac <= frac;

      if (s2_nan)                    q <= 32'h7FC0_0000;
      else if (s2_inf)               q <= {s2_sign, 8'hFF, 23'd0};
      else if (s2_zero)              q <= {s2_sign, 31'd0};
      else if (s2_exp >= 10'sd255)   q <= {s2_sign, 8'hFF, 23'd0};
      else if (s2_exp <= 10'sd0)     q <= {s2_sign, 31'd0};
      else                           q <= {s2_sign, s2_exp[7:0], s2_frac};
    end
  end
endmodule

module vec_elem_mul #(
  parameter int VECTOR_LEN  = 4,
  parameter int MUL_LATENCY = latency::MUL_FP   // mul_fp is hard-wired to 3 stages
) (
  input  logic           clk,
  input  logic           rst,
  vec_elem_mul_if.slave  bus
);
  localparam int IW = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(VECTOR_LEN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                      state;
  logic [VECTOR_LEN-1:0][31:0] copy_a, copy_b, result;
  logic [IW-1:0]               issue_idx;
  logic [31:0]                 op_a, op_b, mul_q;
  logic [MUL_LATENCY:0]        vld_pipe;
  logic [MUL_LATENCY:0][IW-1:0] idx_pipe;
  logic                        done;
  logic                        tail_vld;
  logic [IW-1:0]               tail_idx;

  assign tail_vld = vld_pipe[MUL_LATENCY];
  assign tail_idx = idx_pipe[MUL_LATENCY];

  mul_fp u_mul (.clk(clk), .areset(rst), .a(op_a), .b(op_b), .q(mul_q));

`ifdef VEC_MUL_NONFINITE_EN
  logic nonfinite;
  assign bus.nonfinite = nonfinite;
`endif

  assign bus.result = result;
  assign bus.done   = done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      copy_a    <= '0;
      copy_b    <= '0;
      result    <= '0;
      issue_idx <= '0;
      op_a      <= '0;
      op_b      <= '0;
      vld_pipe  <= '0;
      idx_pipe  <= '0;
      done      <= 1'b0;
`ifdef VEC_MUL_NONFINITE_EN
      nonfinite <= 1'b0;
`endif
    end else begin
      vld_pipe <= {vld_pipe[MUL_LATENCY-1:0], 1'b0};
      idx_pipe <= {idx_pipe[MUL_LATENCY-1:0], issue_idx};

      // Writeback happens on every valid tail, including the edge that aborts.
      if (tail_vld) begin
        result[tail_idx] <= mul_q;
`ifdef VEC_MUL_NONFINITE_EN
        if (mul_q[30:23] == 8'hFF) nonfinite <= 1'b1;
`endif
      end

      case (state)
        IDLE: if (bus.enable) begin
          copy_a    <= bus.vec_a;
          copy_b    <= bus.vec_b;
          issue_idx <= '0;
          state     <= ISSUE;
`ifdef VEC_MUL_NONFINITE_EN
          nonfinite <= 1'b0;
`endif
        end
        ISSUE: begin
          if (!bus.enable) begin
            vld_pipe <= '0;
            state    <= IDLE;
          end else begin
            op_a        <= copy_a[issue_idx];
            op_b        <= copy_b[issue_idx];
            vld_pipe[0] <= 1'b1;
            if (issue_idx == LAST) state <= DRAIN;
            else                   issue_idx <= issue_idx + IW'(1);
          end
        end
        DRAIN: begin
          if (!bus.enable) begin
            vld_pipe <= '0;
            state    <= IDLE;
          end else if (tail_vld && tail_idx == LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (!bus.enable) begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_elem_mul.sv
// Directed table-driven bench for vec_elem_mul: products, done latency, hold, abort, reset.
module tb_vec_elem_mul;
  localparam int N = 4;
  typedef logic [N-1:0][31:0] vec_t;
  typedef struct { vec_t a; vec_t b; vec_t r; } vrec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_elem_mul_if #(.VECTOR_LEN(N)) bus();
  vec_elem_mul #(.VECTOR_LEN(N), .MUL_LATENCY(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  int    nchk  = 0;
  int    nfail = 0;
  vrec_t tbl[5];
  int    lat;
  bit    seen;

  function automatic vec_t mk(input logic [31:0] w0, w1, w2, w3);
    vec_t v;
    v[0] = w0; v[1] = w1; v[2] = w2; v[3] = w3;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Start from IDLE with enable low; returns cycles from E0 to done (-1 on timeout).
  task automatic start_run(input int t, input bit iso, output int l);
    @(negedge clk);
    bus.vec_a  = tbl[t].a;
    bus.vec_b  = tbl[t].b;
    bus.enable = 1'b1;
    @(posedge clk); #1;
    if (iso) bus.vec_a = '0;
    l = -1;
    for (int k = 1; k <= 20 && l < 0; k++) begin
      @(posedge clk); #1;
      if (bus.done) l = k;
    end
  endtask

  task automatic check_run(input int t, input bit iso, input string nm);
    int l;
    start_run(t, iso, l);
    chk({nm, "_latency"}, 128'(l), 128'(8));
    chk({nm, "_result"}, 128'(bus.result), 128'(tbl[t].r));
  endtask

  task automatic drop_enable(input string nm);
    @(negedge clk);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_done_low"}, 128'(bus.done), 128'(0));
  endtask

  initial begin
    tbl[0] = '{a: mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000),
               b: mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000),
               r: mk(32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000)};
    tbl[1] = '{a: mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000),
               b: mk(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000),
               r: mk(32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000)};
    tbl[2] = '{a: mk(32'hBF800000, 32'h40400000, 32'h00000000, 32'h3FC00000),
               b: mk(32'h40000000, 32'hC0000000, 32'h40A00000, 32'h3FC00000),
               r: mk(32'hC0000000, 32'hC0C00000, 32'h00000000, 32'h40100000)};
    tbl[3] = '{a: mk(32'h41200000, 32'h3E800000, 32'h42C80000, 32'h3F400000),
               b: mk(32'h41200000, 32'h41000000, 32'h3F000000, 32'h40800000),
               r: mk(32'h42C80000, 32'h40000000, 32'h42480000, 32'h40400000)};
    tbl[4] = '{a: mk(32'h3F800000, 32'h40000000, 32'h7F800000, 32'h40800000),
               b: mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000),
               r: mk(32'h40000000, 32'h40800000, 32'h7F800000, 32'h41000000)};

    rst = 1'b1;
    bus.enable = 1'b0;
    bus.vec_a = '0;
    bus.vec_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", 128'(bus.done), 128'(0));
    chk("reset_result", 128'(bus.result), 128'(0));
`ifdef VEC_MUL_NONFINITE_EN
    chk("reset_nonfinite", 128'(bus.nonfinite), 128'(0));
`endif
    @(negedge clk);
    rst = 1'b0;

    // Table pass: each run is held in DONE for 5 cycles before enable drops for one cycle.
    for (int t = 0; t < 4; t++) begin
      check_run(t, 1'b0, $sformatf("vec%0d", t));
      for (int h = 0; h < 5; h++) begin
        @(posedge clk); #1;
        chk($sformatf("vec%0d_hold_done", t), 128'(bus.done), 128'(1));
        chk($sformatf("vec%0d_hold_result", t), 128'(bus.result), 128'(tbl[t].r));
      end
      drop_enable($sformatf("vec%0d", t));
      chk($sformatf("vec%0d_kept_result", t), 128'(bus.result), 128'(tbl[t].r));
    end

    // vec_a is zeroed right after E0; the latched copy must still be used.
    check_run(0, 1'b1, "isolation");
    drop_enable("isolation");

    // Abort: enable sampled low at E3, done must never rise.
    @(negedge clk);
    bus.vec_a = tbl[2].a;
    bus.vec_b = tbl[2].b;
    bus.enable = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    bus.enable = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    chk("abort_no_done", 128'(seen), 128'(0));
    check_run(3, 1'b0, "after_abort");
    drop_enable("after_abort");

    // Synchronous reset during DRAIN (after E5, first element already written).
    @(negedge clk);
    bus.vec_a = tbl[0].a;
    bus.vec_b = tbl[0].b;
    bus.enable = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("drain_elem0_written", 128'(bus.result[0]), 128'(tbl[0].r[0]));
    rst = 1'b1;
    bus.enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_done", 128'(bus.done), 128'(0));
    chk("rst_mid_result", 128'(bus.result), 128'(0));
    repeat (6) @(posedge clk);
    #1;
    chk("rst_flush_done", 128'(bus.done), 128'(0));
    chk("rst_flush_result", 128'(bus.result), 128'(0));

    // Reset pulse that never sees a clock edge must leave DONE untouched.
    check_run(1, 1'b0, "pre_glitch");
    @(posedge clk); #1;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    chk("glitch_done", 128'(bus.done), 128'(1));
    chk("glitch_result", 128'(bus.result), 128'(tbl[1].r));
    drop_enable("glitch");

`ifdef VEC_MUL_NONFINITE_EN
    check_run(4, 1'b0, "nonfinite");
    chk("nonfinite_flag", 128'(bus.nonfinite), 128'(1));
    drop_enable("nonfinite");
    chk("nonfinite_held_idle", 128'(bus.nonfinite), 128'(1));
    check_run(0, 1'b0, "finite_after");
    chk("nonfinite_cleared", 128'(bus.nonfinite), 128'(0));
    drop_enable("finite_after");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
